// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and types for the 640x480@60 VGA timing generator.
//   Horizontal and vertical values are expressed in pixels and lines,
//   counted from the start of the sync pulse. That is why the visible window
//   starts after sync plus back porch, and not at zero.
//
//   Contents:
//     CNT_W / RGB_W        counter width and colour width
//     VGA_*                default 640x480 timing (totals, sync widths,
//                          inclusive active bounds) and board-clock divider
//     cnt_t / rgb_t        counter and colour vector types
//     vga_ctrl_t           the three per-pixel control bits (hsync, vsync,
//                          bright) that travel together
//     in_window()          inclusive unsigned range test
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 12;

  // 100 MHz board clock / 4 = 25 MHz pixel rate.
  localparam int unsigned VGA_CLK_DIV  = 4;

  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_ACT_LO = 144;
  localparam int unsigned VGA_H_ACT_HI = 783;

  localparam int unsigned VGA_V_TOTAL  = 525;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_ACT_LO = 35;
  localparam int unsigned VGA_V_ACT_HI = 514;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // Sync outputs are active-low; bright is active-high.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic bright;
  } vga_ctrl_t;

  // Inclusive range test on 10-bit unsigned counts. No wider intermediate is used.
  function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/clk_en_divider.sv
// ---------------------------------------------------------------------------
// clk_en_divider
//   Divides the board clock into a one-cycle enable strobe. It does not
//   produce a derived clock, so the rest of the design stays in a single
//   clock domain and advances only on cycles where pix_en is high.
//
//   Parameters:
//     CLK_DIV   board clocks per strobe (>= 2)
//   Ports:
//     clk       board clock
//     rst       asynchronous reset, active-low
//     pix_en    high for one clk whenever the phase counter sits at CLK_DIV-1
//
//   After reset the phase counter is 0. The first strobe is therefore visible
//   during the CLK_DIV-th clock after release.
// ---------------------------------------------------------------------------
module clk_en_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_pix_en;

  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;

  // The strobe is registered from the next phase value. It goes high in the
  // same cycle in which r_div reads CLK_DIV-1, and it cannot glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register in an edge-triggered block is assigned with <=,
      // so all of them sample pre-edge values and simulation matches hardware.
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_pix_en <= (w_div_nxt == DIV_LAST);
    end
  end

  assign pix_en = r_pix_en;

endmodule

// File: rtl/vga_display_timing.sv
// ---------------------------------------------------------------------------
// vga_display_timing
//   Front end of the game renderer. It produces 640x480@60 raster timing from
//   the 100 MHz board clock, returns the game controller's pixel colour to the
//   VGA pins, and forces that colour to black outside the visible window. It
//   also emits frame_tick, a once-per-frame strobe that paces game-object motion.
//
//   Parameters (defaults from vga_timing_pkg):
//     CLK_DIV                 board clocks per pixel (>= 2)
//     H_TOTAL / V_TOTAL       pixels per line / lines per frame
//     H_SYNC / V_SYNC         sync-low width in pixels / lines
//     H_ACT_LO..H_ACT_HI      visible hCount range, inclusive
//     V_ACT_LO..V_ACT_HI      visible vCount range, inclusive
//   Ports:
//     clk         board clock (single domain)
//     rst         asynchronous reset, active-low
//     rgb_in      colour from the game controller for the current hCount/vCount
//     hCount      horizontal position, 0..H_TOTAL-1
//     vCount      vertical position, 0..V_TOTAL-1
//     bright      high inside the visible window
//     hSync       horizontal sync, active-low
//     vSync       vertical sync, active-low
//     rgb_out     colour to the DAC; zero whenever bright is low
//     pix_en      one-clk pixel strobe, one every CLK_DIV clocks
//     frame_tick  one-clk strobe in the first clock at (0,0) after a frame wraps
//
//   Build option:
//     RGB_PIPE_EN  when defined, rgb_out is registered on pix_en. hSync,
//                  vSync and bright are delayed by one pixel to stay aligned
//                  with it. hCount, vCount and frame_tick are never delayed.
// ---------------------------------------------------------------------------
module vga_display_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_ACT_LO = VGA_H_ACT_LO,
  parameter int unsigned H_ACT_HI = VGA_H_ACT_HI,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_ACT_LO = VGA_V_ACT_LO,
  parameter int unsigned V_ACT_HI = VGA_V_ACT_HI
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic [RGB_W-1:0] rgb_out,
  output logic             pix_en,
  output logic             frame_tick
);

  localparam cnt_t H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam cnt_t H_SYN_C = CNT_W'(H_SYNC);
  localparam cnt_t V_SYN_C = CNT_W'(V_SYNC);
  localparam cnt_t H_LO_C  = CNT_W'(H_ACT_LO);
  localparam cnt_t H_HI_C  = CNT_W'(H_ACT_HI);
  localparam cnt_t V_LO_C  = CNT_W'(V_ACT_LO);
  localparam cnt_t V_HI_C  = CNT_W'(V_ACT_HI);
  localparam cnt_t CNT_ONE = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Pixel-rate enable
  // -------------------------------------------------------------------------
  logic w_pix_en;

  clk_en_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en_divider (
    .clk    (clk),
    .rst    (rst),
    .pix_en (w_pix_en)
  );

  // -------------------------------------------------------------------------
  // Raster counters (next-state logic)
  // -------------------------------------------------------------------------
  cnt_t      r_hcount;
  cnt_t      r_vcount;
  cnt_t      w_hcount_nxt;
  cnt_t      w_vcount_nxt;
  logic      w_h_wrap;
  logic      w_v_wrap;
  logic      w_frame_wrap;
  vga_ctrl_t w_ctrl_nxt;
  vga_ctrl_t r_ctrl;
  logic      r_frame_tick;

  assign w_h_wrap     = (r_hcount == H_LAST);
  assign w_v_wrap     = (r_vcount == V_LAST);
  assign w_frame_wrap = w_pix_en && w_h_wrap && w_v_wrap;

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch
    // is inferred when pix_en is low.
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (w_pix_en) begin
      if (w_h_wrap) begin
        w_hcount_nxt = '0;
        w_vcount_nxt = w_v_wrap ? '0 : r_vcount + CNT_ONE;
      end else begin
        w_hcount_nxt = r_hcount + CNT_ONE;
      end
    end
  end

  // The control bits are decoded from the next-state counts and registered.
  // They therefore change on the same edge as the counters and always
  // describe the counts currently on hCount/vCount.
  always_comb begin
    w_ctrl_nxt.hsync  = !(w_hcount_nxt < H_SYN_C);
    w_ctrl_nxt.vsync  = !(w_vcount_nxt < V_SYN_C);
    w_ctrl_nxt.bright = in_window(w_hcount_nxt, H_LO_C, H_HI_C) &&
                        in_window(w_vcount_nxt, V_LO_C, V_HI_C);
  end

  // -------------------------------------------------------------------------
  // Counter, control and frame-strobe registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_ctrl       <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hcount     <= w_hcount_nxt;
      r_vcount     <= w_vcount_nxt;
      r_ctrl       <= w_ctrl_nxt;
      // Frame_tick is set only by the wrap into (0,0). Leaving reset at
      // (0,0) does not produce a tick.
      r_frame_tick <= w_frame_wrap;
    end
  end

  assign hCount     = r_hcount;
  assign vCount     = r_vcount;
  assign pix_en     = w_pix_en;
  assign frame_tick = r_frame_tick;

  // -------------------------------------------------------------------------
  // Colour return path
  // -------------------------------------------------------------------------
`ifdef RGB_PIPE_EN
  // The colour for a pixel is captured at the end of that pixel. The control
  // bits that described the same pixel are captured with it, so the monitor
  // sees colour, syncs and blanking shifted together by exactly one pixel.
  vga_ctrl_t        r_ctrl_d;
  logic [RGB_W-1:0] r_rgb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these pipeline stages are a few flops rather than a memory, and
      // they are reset so the pins read 0 while rst is low.
      r_ctrl_d <= '0;
      r_rgb    <= '0;
    end else if (w_pix_en) begin
      r_ctrl_d <= r_ctrl;
      r_rgb    <= r_ctrl.bright ? rgb_in : '0;
    end
  end

  assign hSync   = r_ctrl_d.hsync;
  assign vSync   = r_ctrl_d.vsync;
  assign bright  = r_ctrl_d.bright;
  assign rgb_out = r_rgb;
`else
  assign hSync   = r_ctrl.hsync;
  assign vSync   = r_ctrl.vsync;
  assign bright  = r_ctrl.bright;
  assign rgb_out = r_ctrl.bright ? rgb_in : '0;
`endif

endmodule
